// File: rtl/nes_controller_ports.sv
// NES controller ports on the CPU bus at $4016+p: per-port shadow keycodes, a strobe
// latch, and per-port shift registers serialised one bit per CPU read.
//
// Ports:
//   clk, reset      - system clock, async active-high reset
//   wren, data_in   - CPU write to $4016; data_in[0] sets the strobe latch
//   rden, port_sel  - CPU read of port port_sel; data_out valid in the same cycle
//   open_bus        - last CPU bus value, drives data_out[7:5]
//   keycode_*       - NIOS shadow keycode write (bit 0 = A, read first)
//   data_out        - {open_bus[7:5], 4'b0000, serial_bit}
//   strobe          - current strobe latch
//   read_count      - per-port 5-bit saturating read counters, port p at [p*5 +: 5]
module nes_controller_ports #(
    parameter int   NUM_PORTS = 2,
    parameter int   BITS      = 8,
    parameter logic FILL      = 1'b1,
    parameter int   PSEL_W    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wren,
    input  logic                   rden,
    input  logic [PSEL_W-1:0]      port_sel,
    input  logic [7:0]             data_in,
    input  logic [7:0]             open_bus,
    input  logic                   keycode_we,
    input  logic [PSEL_W-1:0]      keycode_port,
    input  logic [BITS-1:0]        keycode_data,
    output logic [7:0]             data_out,
    output logic                   strobe,
    output logic [NUM_PORTS*5-1:0] read_count
);

    logic [BITS-1:0] shadow [NUM_PORTS];
    logic [BITS-1:0] shift  [NUM_PORTS];
    logic [4:0]      cnt    [NUM_PORTS];
    logic            strobe_next;
    logic            serial_bit;
    logic            unused_bits;

    // A write in this cycle overrides the latch for load/shift decisions.
    assign strobe_next = wren ? data_in[0] : strobe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                shadow[p] <= '0;
                shift[p]  <= '0;
                cnt[p]    <= '0;
            end
        end else begin
            if (wren)
                strobe <= data_in[0];
            for (int p = 0; p < NUM_PORTS; p++) begin
                // Out-of-range indices match no port and are dropped.
                if (keycode_we && keycode_port == PSEL_W'(p))
                    shadow[p] <= keycode_data;
                // Load samples the pre-write shadow (non-blocking read).
                if (strobe_next) begin
                    shift[p] <= shadow[p];
                    cnt[p]   <= '0;
                end else if (rden && port_sel == PSEL_W'(p)) begin
                    shift[p] <= BITS'({FILL, shift[p]} >> 1);
                    if (cnt[p] != 5'd31)
                        cnt[p] <= cnt[p] + 5'd1;
                end
            end
        end
    end

    // While strobe is high the A button is seen live from the shadow.
    always_comb begin
        serial_bit = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_sel == PSEL_W'(p))
                serial_bit = strobe ? shadow[p][0] : shift[p][0];
        end
    end

    assign data_out = {open_bus[7:5], 4'b0000, serial_bit};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign read_count[g*5 +: 5] = cnt[g];
    end

    assign unused_bits = ^{data_in[7:1], open_bus[4:0]};

endmodule
